// File: rtl/regfile_wr_arbiter_if.sv
// Request buses (P, L, D) and register-file write port of regfile_wr_arbiter.
// The slave modport is the arbiter side; the master modport is the requester/consumer side.
interface regfile_wr_arbiter_if #(
    parameter int XLEN       = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int L_DEPTH    = 4
);
    logic                        i_pValid;
    logic [ADDR_WIDTH-1:0]       i_pAddr;
    logic [XLEN-1:0]             i_pData;
    logic                        i_lValid;
    logic                        o_lReady;
    logic [ADDR_WIDTH-1:0]       i_lAddr;
    logic [XLEN-1:0]             i_lData;
    logic                        i_dValid;
    logic                        o_dReady;
    logic [ADDR_WIDTH-1:0]       i_dAddr;
    logic [XLEN-1:0]             i_dData;
    logic                        o_wrEn;
    logic [ADDR_WIDTH-1:0]       o_rdAddr;
    logic [XLEN-1:0]             o_rdData;
    logic                        o_initDone;
    logic                        o_err;
    logic [$clog2(L_DEPTH):0]    o_lCount;

    modport slave (
        input  i_pValid, i_pAddr, i_pData,
        input  i_lValid, i_lAddr, i_lData,
        input  i_dValid, i_dAddr, i_dData,
        output o_lReady, o_dReady,
        output o_wrEn, o_rdAddr, o_rdData,
        output o_initDone, o_err, o_lCount
    );

    modport master (
        output i_pValid, i_pAddr, i_pData,
        output i_lValid, i_lAddr, i_lData,
        output i_dValid, i_dAddr, i_dData,
        input  o_lReady, o_dReady,
        input  o_wrEn, o_rdAddr, o_rdData,
        input  o_initDone, o_err, o_lCount
    );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port owner: zeroes every entry after reset, then arbitrates
// pipeline (P) > long-latency queue (L) > debug (D), with a starvation override for D.
module regfile_wr_arbiter #(
    parameter int XLEN         = 32,
    parameter int ADDR_WIDTH   = 5,
    parameter int L_DEPTH      = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rstN,
    regfile_wr_arbiter_if.slave  bus
);
    localparam int LW = $clog2(L_DEPTH);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t                      state;
    logic [ADDR_WIDTH-1:0]       clr_cnt;
    logic [LW:0]                 wr_ptr;
    logic [LW:0]                 rd_ptr;
    logic [ADDR_WIDTH+XLEN-1:0]  lq_mem [L_DEPTH];
    logic [SW-1:0]               starve_cnt;
    logic                        err;

    logic                        run;
    logic                        lq_empty;
    logic                        lq_full;
    logic                        starved;
    logic [ADDR_WIDTH-1:0]       lq_head_addr;
    logic [XLEN-1:0]             lq_head_data;
    logic                        l_rdy;
    logic                        d_rdy;
    logic                        l_push;
    logic                        l_pop;
    logic                        d_acc;

    logic                        vld_p0;
    logic                        wr_p0;
    logic [ADDR_WIDTH-1:0]       addr_p0;
    logic [XLEN-1:0]             data_p0;

    logic                        vld_p1;
    logic [ADDR_WIDTH-1:0]       addr_p1;
    logic [XLEN-1:0]             data_p1;

    assign run      = (state == RUN);
    assign lq_empty = (wr_ptr == rd_ptr);
    assign lq_full  = (wr_ptr[LW] != rd_ptr[LW]) && (wr_ptr[LW-1:0] == rd_ptr[LW-1:0]);
    assign starved  = (starve_cnt >= STARVE_MAX);
    assign {lq_head_addr, lq_head_data} = lq_mem[rd_ptr[LW-1:0]];

    assign l_rdy  = run && !lq_full;
    assign d_rdy  = run && !bus.i_pValid && (starved || lq_empty);
    assign l_push = bus.i_lValid && l_rdy;

    // Stage p0: pick one write source for this cycle
    always_comb begin
        vld_p0  = 1'b0;
        addr_p0 = '0;
        data_p0 = '0;
        l_pop   = 1'b0;
        d_acc   = 1'b0;
        if (!run) begin
            vld_p0  = 1'b1;
            addr_p0 = clr_cnt;
        end else if (bus.i_pValid) begin
            vld_p0  = 1'b1;
            addr_p0 = bus.i_pAddr;
            data_p0 = bus.i_pData;
        end else if (bus.i_dValid && starved) begin
            vld_p0  = 1'b1;
            addr_p0 = bus.i_dAddr;
            data_p0 = bus.i_dData;
            d_acc   = 1'b1;
        end else if (!lq_empty) begin
            vld_p0  = 1'b1;
            addr_p0 = lq_head_addr;
            data_p0 = lq_head_data;
            l_pop   = 1'b1;
        end else if (bus.i_dValid) begin
            vld_p0  = 1'b1;
            addr_p0 = bus.i_dAddr;
            data_p0 = bus.i_dData;
            d_acc   = 1'b1;
        end
    end

    // x0 is hardwired zero in RUN, so a selected x0 write is consumed without a write strobe
    assign wr_p0 = vld_p0 && (!run || (addr_p0 != '0));

    always_ff @(posedge i_clk) begin
        if (l_push) begin
            lq_mem[wr_ptr[LW-1:0]] <= {bus.i_lAddr, bus.i_lData};
        end
    end

    always_ff @(posedge i_clk or negedge i_rstN) begin
        if (!i_rstN) begin
            state      <= CLEAR;
            clr_cnt    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            starve_cnt <= '0;
            err        <= 1'b0;
            vld_p1     <= 1'b0;
            addr_p1    <= '0;
            data_p1    <= '0;
        end else begin
            if (!run) begin
                clr_cnt <= clr_cnt + 1'b1;
                if (&clr_cnt) begin
                    state <= RUN;
                end
                if (bus.i_pValid) begin
                    err <= 1'b1;
                end
            end
            if (l_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (l_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (bus.i_dValid && !d_acc) begin
                if (!starved) begin
                    starve_cnt <= starve_cnt + 1'b1;
                end
            end else begin
                starve_cnt <= '0;
            end
            // Stage p1: registered write port; address/data hold when idle
            vld_p1 <= wr_p0;
            if (wr_p0) begin
                addr_p1 <= addr_p0;
                data_p1 <= data_p0;
            end
        end
    end

    assign bus.o_wrEn     = vld_p1;
    assign bus.o_rdAddr   = addr_p1;
    assign bus.o_rdData   = data_p1;
    assign bus.o_initDone = run;
    assign bus.o_err      = err;
    assign bus.o_lReady   = l_rdy;
    assign bus.o_dReady   = d_rdy;
    assign bus.o_lCount   = wr_ptr - rd_ptr;
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Scoreboard bench for regfile_wr_arbiter: a behavioural arbiter model predicts readies,
// queue occupancy and the ordered stream of register-file writes.
module tb_regfile_wr_arbiter;
    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    logic i_clk;
    logic i_rstN;

    regfile_wr_arbiter_if #(.XLEN(32), .ADDR_WIDTH(5), .L_DEPTH(4)) bus ();

    regfile_wr_arbiter #(
        .XLEN(32), .ADDR_WIDTH(5), .L_DEPTH(4), .STARVE_LIMIT(8)
    ) dut (
        .i_clk  (i_clk),
        .i_rstN (i_rstN),
        .bus    (bus)
    );

    int  n_chk  = 0;
    int  n_fail = 0;
    wr_t exp_q [$];
    wr_t lpend [$];
    int  m_starve = 0;
    bit  m_wr_pending = 1'b0;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Every register-file write must match the next expected write, in order
    always @(negedge i_clk) begin
        if (i_rstN && bus.o_wrEn) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_wr", 1, 0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("sb_addr", bus.o_rdAddr, e.a);
                chk("sb_data", bus.o_rdData, e.d);
            end
        end
    end

    task automatic drive_idle();
        bus.i_pValid = 1'b0; bus.i_pAddr = '0; bus.i_pData = '0;
        bus.i_lValid = 1'b0; bus.i_lAddr = '0; bus.i_lData = '0;
        bus.i_dValid = 1'b0; bus.i_dAddr = '0; bus.i_dData = '0;
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, "_wren"},  bus.o_wrEn, 0);
        chk({tag, "_addr"},  bus.o_rdAddr, 0);
        chk({tag, "_data"},  bus.o_rdData, 0);
        chk({tag, "_done"},  bus.o_initDone, 0);
        chk({tag, "_err"},   bus.o_err, 0);
        chk({tag, "_lrdy"},  bus.o_lReady, 0);
        chk({tag, "_drdy"},  bus.o_dReady, 0);
        chk({tag, "_lcnt"},  bus.o_lCount, 0);
    endtask

    task automatic model_clear();
        exp_q.delete();
        lpend.delete();
        m_starve     = 0;
        m_wr_pending = 1'b0;
    endtask

    // Release reset and follow the clear pass; optionally pulse P mid-clear
    task automatic do_init(input bit pulse_p);
        model_clear();
        for (int i = 0; i < 32; i++) exp_q.push_back('{a: 5'(i), d: 32'h0});
        @(negedge i_clk);
        #1 i_rstN = 1'b1;
        for (int i = 0; i < 32; i++) begin
            @(negedge i_clk);
            chk("clr_wren", bus.o_wrEn, 1);
            chk("clr_addr", bus.o_rdAddr, i);
            chk("init_done", bus.o_initDone, (i == 31));
            chk("clr_err", bus.o_err, (pulse_p && i >= 5));
            if (i < 31) begin
                chk("clr_lrdy", bus.o_lReady, 0);
                chk("clr_drdy", bus.o_dReady, 0);
            end
            bus.i_pValid = pulse_p && (i == 4);
            bus.i_pAddr  = 5'd9;
            bus.i_pData  = 32'hDEAD;
        end
        drive_idle();
        m_wr_pending = 1'b0;
    endtask

    task automatic assert_reset();
        @(negedge i_clk);
        #2 i_rstN = 1'b0;
        drive_idle();
        #1 check_reset_outs("rst_mid");
        model_clear();
    endtask

    // One RUN cycle: drive, check readies/occupancy/strobe, then advance the model
    task automatic step(input logic pv, input logic [4:0] pa, input logic [31:0] pd,
                        input logic lv, input logic [4:0] la, input logic [31:0] ld,
                        input logic dv, input logic [4:0] da, input logic [31:0] dd,
                        output logic got_l, output logic got_d);
        bit  starved, empty, full, e_lrdy, e_drdy, has_sel, d_acc;
        wr_t sel;
        @(posedge i_clk);
        #1;
        bus.i_pValid = pv; bus.i_pAddr = pa; bus.i_pData = pd;
        bus.i_lValid = lv; bus.i_lAddr = la; bus.i_lData = ld;
        bus.i_dValid = dv; bus.i_dAddr = da; bus.i_dData = dd;
        starved = (m_starve >= 8);
        empty   = (lpend.size() == 0);
        full    = (lpend.size() == 4);
        e_lrdy  = !full;
        e_drdy  = !pv && (starved || empty);
        @(negedge i_clk);
        got_l = bus.o_lReady;
        got_d = bus.o_dReady;
        chk("l_ready", got_l, e_lrdy);
        chk("d_ready", got_d, e_drdy);
        chk("l_count", bus.o_lCount, lpend.size());
        chk("wr_en", bus.o_wrEn, m_wr_pending);
        has_sel = 1'b1;
        sel     = '{a: 5'd0, d: 32'h0};
        if (pv)                 sel = '{a: pa, d: pd};
        else if (dv && starved) sel = '{a: da, d: dd};
        else if (!empty)        sel = lpend.pop_front();
        else if (dv)            sel = '{a: da, d: dd};
        else                    has_sel = 1'b0;
        d_acc = dv && e_drdy;
        if (lv && e_lrdy) lpend.push_back('{a: la, d: ld});
        m_wr_pending = has_sel && (sel.a != 5'd0);
        if (m_wr_pending) exp_q.push_back(sel);
        if (dv && !d_acc) m_starve = (m_starve < 8) ? m_starve + 1 : 8;
        else              m_starve = 0;
    endtask

    task automatic idle(output logic gl, output logic gd);
        step(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, gl, gd);
    endtask

    task automatic sb_empty(input string tag);
        #1 chk(tag, exp_q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic gl, gd;
        int   l_idx, waits;
        bit   acc;
        i_rstN = 1'b0;
        drive_idle();
        @(negedge i_clk);
        check_reset_outs("rst");

        do_init(1'b0);
        idle(gl, gd);
        idle(gl, gd);

        // P and a queued L in the same cycle: P first, L next
        step(0, 5'd0, 32'h0, 1, 5'd4, 32'h5, 0, 5'd0, 32'h0, gl, gd);
        step(1, 5'd3, 32'hAAAA0001, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, gl, gd);
        idle(gl, gd);
        chk("p_first_addr", bus.o_rdAddr, 3);
        idle(gl, gd);
        chk("l_second_addr", bus.o_rdAddr, 4);
        chk("l_second_data", bus.o_rdData, 32'h5);
        idle(gl, gd);
        sb_empty("sb_p_over_l");

        // P every cycle fills the L queue
        l_idx = 0;
        for (int c = 0; c < 5; c++) begin
            step(1, 5'd7, 32'h100 + 32'(c), 1, 5'(10 + l_idx), 32'h200 + 32'(l_idx),
                 0, 5'd0, 32'h0, gl, gd);
            if (gl) l_idx++;
        end
        chk("l_full_rdy", gl, 0);
        chk("l_full_cnt", bus.o_lCount, 4);
        step(0, 5'd0, 32'h0, 1, 5'(10 + l_idx), 32'h200 + 32'(l_idx), 0, 5'd0, 32'h0, gl, gd);
        step(1, 5'd7, 32'h1FF, 1, 5'(10 + l_idx), 32'h200 + 32'(l_idx), 0, 5'd0, 32'h0, gl, gd);
        chk("l_rdy_back", gl, 1);
        chk("l_out_addr", bus.o_rdAddr, 10);
        for (int c = 0; c < 6; c++) idle(gl, gd);
        chk("l_drained", bus.o_lCount, 0);
        sb_empty("sb_l_fill");

        // D starves behind a non-empty L queue, then overrides it
        step(0, 5'd0, 32'h0, 1, 5'd12, 32'hE0, 0, 5'd0, 32'h0, gl, gd);
        waits = 0;
        acc   = 1'b0;
        for (int k = 0; k < 12 && !acc; k++) begin
            step(0, 5'd0, 32'h0, 1, 5'(13 + k), 32'hE1 + 32'(k), 1, 5'd20, 32'hD0D0, gl, gd);
            if (gd) acc = 1'b1;
            else    waits++;
        end
        chk("d_starve_wait", waits, 8);
        chk("d_accepted", acc, 1);
        step(0, 5'd0, 32'h0, 1, 5'd30, 32'hEF, 1, 5'd21, 32'h0D0D, gl, gd);
        chk("d_out_addr", bus.o_rdAddr, 20);
        chk("d_out_data", bus.o_rdData, 32'hD0D0);
        chk("starve_cleared", gd, 0);
        for (int c = 0; c < 4; c++) idle(gl, gd);
        sb_empty("sb_starve");

        // x0 writes are consumed without a write strobe
        step(1, 5'd0, 32'h1234, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, gl, gd);
        idle(gl, gd);
        chk("x0_p_wren", bus.o_wrEn, 0);
        step(0, 5'd0, 32'h0, 1, 5'd0, 32'h77, 0, 5'd0, 32'h0, gl, gd);
        idle(gl, gd);
        idle(gl, gd);
        chk("x0_l_cnt", bus.o_lCount, 0);
        chk("x0_l_wren", bus.o_wrEn, 0);
        idle(gl, gd);
        sb_empty("sb_x0");

        // P during CLEAR sets the sticky error
        assert_reset();
        do_init(1'b1);
        idle(gl, gd);
        idle(gl, gd);
        chk("err_sticky", bus.o_err, 1);

        // Reset mid-RUN with L entries queued restarts everything
        for (int c = 0; c < 3; c++) begin
            step(1, 5'd6, 32'h60 + 32'(c), 1, 5'(1 + c), 32'h300 + 32'(c), 0, 5'd0, 32'h0, gl, gd);
        end
        step(1, 5'd6, 32'h67, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, gl, gd);
        chk("pre_rst_cnt", bus.o_lCount, 3);
        chk("pre_rst_err", bus.o_err, 1);
        assert_reset();
        do_init(1'b0);
        idle(gl, gd);
        idle(gl, gd);
        sb_empty("sb_restart");

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
- Owns the single write port of the register file and shares it between three requesters:
  - pipeline writeback (P);
  - long-latency unit writeback (L, e.g. divider/load return);
  - debug port (D).
- After reset it sequences a clear pass that zeroes every register-file entry, because BRAM contents are undefined after reset.
- It then arbitrates P > L > D, with a starvation override for D.
- Its registered outputs drive the register file's write-enable, write-address and write-data inputs directly.

Parameters:
- XLEN, 32, data width.
- ADDR_WIDTH, 5, register address width; the clear pass covers 2^ADDR_WIDTH entries.
- L_DEPTH, 4, L-queue depth in entries; power of two, minimum 2.
- STARVE_LIMIT, 8, number of consecutive cycles D may wait while valid before it outranks L.

Ports:
- i_clk  in  1  clock.
- i_rstN  in  1  asynchronous active-low reset.
- i_pValid  in  1  P write request. Has no ready signal and is always accepted in RUN.
- i_pAddr  in  ADDR_WIDTH  P destination register.
- i_pData  in  XLEN  P write data.
- i_lValid  in  1  L write request.
- o_lReady  out  1  L accepted when i_lValid && o_lReady.
- i_lAddr  in  ADDR_WIDTH  L destination register.
- i_lData  in  XLEN  L write data.
- i_dValid  in  1  D write request.
- o_dReady  out  1  D accepted when i_dValid && o_dReady.
- i_dAddr  in  ADDR_WIDTH  D destination register.
- i_dData  in  XLEN  D write data.
- o_wrEn  out  1  register-file write enable.
- o_rdAddr  out  ADDR_WIDTH  register-file write address.
- o_rdData  out  XLEN  register-file write data.
- o_initDone  out  1  high while in state RUN.
- o_err  out  1  sticky error: set when P is valid during CLEAR.
- o_lCount  out  log2(L_DEPTH)+1  current L-queue occupancy.

Behaviour:
- Reset (async assert, i_rstN=0):
  - state=CLEAR, clear counter=0, L-queue emptied, starvation counter=0.
  - Outputs: o_wrEn=0, o_rdAddr=0, o_rdData=0, o_initDone=0, o_err=0, o_lReady=0, o_dReady=0.
  - A reset asserted mid-operation discards queued L entries and restarts the clear pass.
- State CLEAR:
  - Each cycle selects write {addr=counter, data=0}; counter increments.
  - After 2^ADDR_WIDTH selections (x0 included), next state is RUN.
  - o_lReady=0 and o_dReady=0 throughout.
  - P valid in CLEAR: the request is dropped and o_err is set. o_err is cleared only by reset.
- State RUN: each cycle the arbiter picks at most one source:
  1. P if i_pValid.
  2. Otherwise D, if i_dValid and the starvation counter is at or above STARVE_LIMIT.
  3. Otherwise the L-queue head, if the queue is non-empty.
  4. Otherwise D, if i_dValid.
- Ready signals:
  - o_dReady = RUN && !i_pValid && (starved || Lqueue empty).
  - o_lReady = RUN && Lqueue not full. An L push in the same cycle as an L pop is legal.
- L path:
  - An accepted L request is enqueued.
  - It can be selected no earlier than the cycle after it is accepted; there is no bypass.
- Starvation counter:
  - Increments, saturating at STARVE_LIMIT, each cycle i_dValid is high and D is not accepted.
  - Resets to 0 when D is accepted or i_dValid is low.
- Output register:
  - The selected write is registered; o_wrEn/o_rdAddr/o_rdData show it exactly 1 cycle after selection.
  - With no selection, o_wrEn=0 and the address/data outputs hold their previous values.
- x0 writes:
  - In RUN, a selected write with address 0 is consumed (handshake completes, queue entry popped) but produces o_wrEn=0.
  - In CLEAR, x0 is written with 0.
- Read-during-write forwarding is handled downstream by the register file. This block never stalls P.
- o_initDone is registered state==RUN. It rises on the same edge that presents the last clear write (addr 2^ADDR_WIDTH-1) on the outputs.

Test Plan:
- Release reset with no requests:
  - o_wrEn=1 for 32 consecutive cycles with o_rdAddr 0..31 and o_rdData=0.
  - o_initDone rises with the addr-31 write.
  - The cycle after, o_wrEn=0.
- In RUN, P(addr 3, 0xAAAA0001) and a queued L(addr 4, 0x5) in the same cycle:
  - Cycle+1: write addr 3, 0xAAAA0001.
  - Next cycle: write addr 4, 0x5.
- P valid every cycle; push 5 L requests with L_DEPTH=4:
  - o_lReady drops after 4 accepts and o_lCount=4.
  - Drop P for 1 cycle: one L write appears at the outputs, then o_lReady re-asserts.
- D valid continuously while L is kept non-empty and P is idle:
  - o_dReady stays 0 for 8 cycles.
  - D is accepted on the 9th cycle; its write appears 1 cycle later; the starvation counter returns to 0.
- P write to addr 0 with data 0x1234 in RUN -> o_wrEn stays 0. L write to addr 0 -> handshake completes, o_lCount decrements, o_wrEn=0.
- P valid during CLEAR -> o_err=1 and stays 1 through RUN. Assert i_rstN mid-RUN with 3 L entries queued -> o_lCount=0, o_err=0, and the clear pass restarts at addr 0.
